// File: rtl/concat_reduce_pipe_if.sv
// rtl/concat_reduce_pipe_if.sv - handshake, data and checksum bundle for concat_reduce_pipe
interface concat_reduce_pipe_if #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int OUT_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NCH*W-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               sum_clr;
  logic [OUT_W-1:0]   checksum;
  logic [15:0]        count;

  modport master (
    output in_valid, in_data, out_ready, sum_clr,
    input  in_ready, out_valid, out_data, checksum, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, sum_clr,
    output in_ready, out_valid, out_data, checksum, count
  );
endinterface

// File: rtl/concat_reduce_pipe.sv
// rtl/concat_reduce_pipe.sv - two-stage channel reduce pipeline with XOR checksum and count
// Stage 1 reduces the channels to cond/par, stage 2 forms the result; both stall on backpressure.
module concat_reduce_pipe #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int OUT_W = 32,
  parameter int SEXT  = 0
) (
  input logic               clk,
  input logic               rst,
  concat_reduce_pipe_if.slave bus
);
  localparam logic [OUT_W-1:0] ONE_EXT =
    (SEXT != 0) ? {OUT_W{1'b1}} : {{(OUT_W-1){1'b0}}, 1'b1};

  logic             v1, v2;
  logic             cond_q, par_q;
  logic             en1, en2, xfer;
  logic [W-1:0]     xall;
  logic [OUT_W-1:0] data_q, sum_q;
  logic [15:0]      cnt_q;

  always_comb begin
    xall = '0;
    for (int k = 0; k < NCH; k++) begin
      xall = xall ^ bus.in_data[k*W +: W];
    end
  end

  assign en2  = !v2 || bus.out_ready;
  assign en1  = !v1 || en2;
  assign xfer = v2 && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      cond_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (en1) begin
      v1     <= bus.in_valid;
      cond_q <= |bus.in_data[(NCH-1)*W +: W];
      par_q  <= ~^xall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      data_q <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        data_q <= cond_q ? ONE_EXT : {{(OUT_W-1){1'b0}}, par_q};
      end
    end
  end

  // A clear coinciding with a transfer discards that beat's contribution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (bus.sum_clr) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q ^ data_q;
      if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2;
  assign bus.out_data  = data_q;
  assign bus.checksum  = sum_q;
  assign bus.count     = cnt_q;
endmodule

// File: tb/tb_concat_reduce_pipe.sv
// tb/tb_concat_reduce_pipe.sv - directed table-driven bench for concat_reduce_pipe (SEXT=0 and SEXT=1)
module tb_concat_reduce_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        sum_clr;

  int n_chk  = 0;
  int n_fail = 0;

  concat_reduce_pipe_if #(.NCH(4), .W(8), .OUT_W(32)) bus0 ();
  concat_reduce_pipe_if #(.NCH(4), .W(8), .OUT_W(32)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus0.sum_clr   = sum_clr;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;
  assign bus1.sum_clr   = sum_clr;

  concat_reduce_pipe #(.NCH(4), .W(8), .OUT_W(32), .SEXT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  concat_reduce_pipe #(.NCH(4), .W(8), .OUT_W(32), .SEXT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t        vt[8];
  logic [31:0] bd[4];
  logic [31:0] be0[4];
  logic [31:0] be1[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] e0, input logic [31:0] e1);
    chk({nm, " out_valid0"}, 32'(bus0.out_valid), 32'(v));
    chk({nm, " out_valid1"}, 32'(bus1.out_valid), 32'(v));
    if (v) begin
      chk({nm, " out_data0"}, bus0.out_data, e0);
      chk({nm, " out_data1"}, bus1.out_data, e1);
    end
  endtask

  task automatic chk_sum(input string nm, input logic [31:0] c0, input logic [31:0] c1, input logic [15:0] cnt);
    chk({nm, " checksum0"}, bus0.checksum, c0);
    chk({nm, " checksum1"}, bus1.checksum, c1);
    chk({nm, " count0"}, 32'(bus0.count), 32'(cnt));
    chk({nm, " count1"}, 32'(bus1.count), 32'(cnt));
  endtask

  task automatic clear_sums();
    @(negedge clk);
    sum_clr = 1'b1;
    @(negedge clk);
    sum_clr = 1'b0;
    chk_sum("clear", 32'h0, 32'h0, 16'd0);
  endtask

  // Back-to-back beats with out_ready held high, one result per cycle.
  task automatic burst(input string nm, input int n, input logic [31:0] c0, input logic [31:0] c1);
    clear_sums();
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) chk_out(nm, 1'b1, be0[i-2], be1[i-2]);
      in_valid = (i < n);
      if (i < n) begin
        in_data = bd[i];
        chk({nm, " in_ready"}, 32'(bus0.in_ready), 32'h1);
      end
    end
    @(negedge clk);
    chk_out({nm, " drained"}, 1'b0, 32'h0, 32'h0);
    chk_sum(nm, c0, c1, 16'(n));
  endtask

  initial begin
    vt[0] = '{32'h00010204, 32'h00000000, 32'h00000000};
    vt[1] = '{32'h00000003, 32'h00000001, 32'h00000001};
    vt[2] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vt[3] = '{32'h00000000, 32'h00000001, 32'h00000001};
    vt[4] = '{32'h01000000, 32'h00000001, 32'hFFFFFFFF};
    vt[5] = '{32'h000000FF, 32'h00000001, 32'h00000001};
    vt[6] = '{32'h00000001, 32'h00000000, 32'h00000000};
    vt[7] = '{32'h00FF7F00, 32'h00000000, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sum_clr = 1'b0;
    #1;
    chk("reset in_ready", 32'(bus0.in_ready), 32'h1);
    chk_out("reset", 1'b0, 32'h0, 32'h0);
    chk("reset out_data0", bus0.out_data, 32'h0);
    chk_sum("reset", 32'h0, 32'h0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single beats: exact 2-cycle latency and result value.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vt[i].din;
      chk("vec in_ready", 32'(bus0.in_ready), 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("vec lat1", 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].exp0, vt[i].exp1);
      @(negedge clk);
      chk_out("vec after", 1'b0, 32'h0, 32'h0);
    end

    bd[0] = 32'h00000003; be0[0] = 32'h1; be1[0] = 32'h1;
    bd[1] = 32'h00010204; be0[1] = 32'h0; be1[1] = 32'h0;
    bd[2] = 32'h80000000; be0[2] = 32'h1; be1[2] = 32'hFFFFFFFF;
    burst("burst101", 3, 32'h0, 32'hFFFFFFFE);

    bd[0] = 32'h80000000; be0[0] = 32'h1; be1[0] = 32'hFFFFFFFF;
    bd[1] = 32'h00000003; be0[1] = 32'h1; be1[1] = 32'h1;
    burst("burstF1", 2, 32'h0, 32'hFFFFFFFE);

    // Backpressure: two beats buffered, third refused, output held.
    clear_sums();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000003;
    chk("stall in_ready a", 32'(bus0.in_ready), 32'h1);
    @(negedge clk);
    in_data = 32'h00010204;
    chk("stall in_ready b", 32'(bus0.in_ready), 32'h1);
    @(negedge clk);
    in_data = 32'h80000000;
    chk("stall in_ready c", 32'(bus0.in_ready), 32'h0);
    chk_out("stall hold0", 1'b1, 32'h1, 32'h1);
    @(negedge clk);
    chk("stall in_ready c2", 32'(bus1.in_ready), 32'h0);
    chk_out("stall hold1", 1'b1, 32'h1, 32'h1);
    @(negedge clk);
    chk_out("stall hold2", 1'b1, 32'h1, 32'h1);
    out_ready = 1'b1;
    #1;
    chk("stall release in_ready", 32'(bus0.in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("stall beat b", 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("stall beat c", 1'b1, 32'h1, 32'hFFFFFFFF);
    @(negedge clk);
    chk_out("stall drained", 1'b0, 32'h0, 32'h0);
    chk_sum("stall", 32'h0, 32'hFFFFFFFE, 16'd3);

    // Clear coinciding with the second of two transfers.
    clear_sums();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000003;
    @(negedge clk);
    in_data = 32'h80000000;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("clr beat1", 1'b1, 32'h1, 32'h1);
    @(negedge clk);
    chk_out("clr beat2", 1'b1, 32'h1, 32'hFFFFFFFF);
    chk_sum("clr pre", 32'h1, 32'h1, 16'd1);
    sum_clr = 1'b1;
    @(negedge clk);
    sum_clr = 1'b0;
    chk_out("clr drained", 1'b0, 32'h0, 32'h0);
    chk_sum("clr win", 32'h0, 32'h0, 16'd0);

    // Build nonzero sums, fill the pipe, then reset mid-cycle.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h80000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_sum("rst pre", 32'h1, 32'hFFFFFFFF, 16'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000003;
    @(negedge clk);
    in_data = 32'h00010204;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("rst full", 1'b1, 32'h1, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_out("rst async", 1'b0, 32'h0, 32'h0);
    chk("rst async out_data", bus0.out_data, 32'h0);
    chk("rst async in_ready", 32'(bus0.in_ready), 32'h1);
    chk_sum("rst async", 32'h0, 32'h0, 16'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h00000000;
    chk("rst first accept", 32'(bus0.in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("rst no stale a", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("rst new beat", 1'b1, 32'h1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("rst no stale b", 1'b0, 32'h0, 32'h0);
    end
    chk_sum("rst post", 32'h1, 32'h1, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/concat_reduce_pipe.md
CONCAT_REDUCE_PIPE -- requirements
Module: concat_reduce_pipe

Interface
REQ-001 The block SHALL have parameter NCH, default 4, the number of input channels (NCH >= 1).
REQ-002 The block SHALL have parameter W, default 8, the width of each channel in bits (W >= 1).
REQ-003 The block SHALL have parameter OUT_W, default 32, the output and checksum width (OUT_W >= 2).
REQ-004 The block SHALL have parameter SEXT, default 0: 0 = zero-extend the 1-bit select result, 1 = sign-extend it.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input beat present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-009 The block SHALL have port in_data, input, NCH*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, OUT_W bits: result.
REQ-013 The block SHALL have port sum_clr, input, 1 bit: synchronous clear of checksum and count.
REQ-014 The block SHALL have port checksum, output, OUT_W bits: XOR accumulation of transferred results.
REQ-015 The block SHALL have port count, output, 16 bits: number of transferred results, saturating.

Function
REQ-016 The block SHALL accept an input beat when in_valid and in_ready are both 1 in the same cycle, and a result SHALL transfer when out_valid and out_ready are both 1.
REQ-017 Stage 1 SHALL register cond = reduction-OR of channel NCH-1, and par = reduction-XNOR of (ch[0] ^ ch[1] ^ ... ^ ch[NCH-1]), a W-bit XOR followed by a 1-bit reduction.
REQ-018 Stage 2 SHALL register out_data as follows: if cond = 1, out_data = ext(1'b1), where ext gives all ones when SEXT=1 and 1 when SEXT=0; otherwise out_data = par zero-extended to OUT_W.
REQ-019 Stage-valid flags v1 and v2 SHALL be kept, with out_valid = v2.
REQ-020 Stage-2 enable SHALL be en2 = !v2 | out_ready.
REQ-021 Stage-1 enable SHALL be en1 = !v1 | en2.
REQ-022 in_ready SHALL be combinational and equal to en1.
REQ-023 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid=1, with no stall.
REQ-024 Sustained throughput SHALL be 1 beat per cycle while out_ready = 1.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL hold stable and stage 1 SHALL hold its contents; at most 2 beats SHALL be buffered, after which in_ready = 0.
REQ-026 Beats SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-027 Each transfer SHALL update checksum to checksum ^ out_data and count to count + 1, with count saturating at 16'hFFFF.
REQ-028 sum_clr=1 SHALL set checksum = 0 and count = 0 on the next edge; when it coincides with a transfer, the clear SHALL win and the beat SHALL NOT be accumulated.
REQ-029 sum_clr SHALL NOT affect the pipeline contents or the handshake signals.

Reset
REQ-030 While rst=1 the block SHALL immediately (asynchronously) force v1=0, v2=0, out_valid=0, out_data=0, checksum=0 and count=0.
REQ-031 While rst=1, in_ready SHALL read 1.
REQ-032 Beats in flight when rst is asserted SHALL be discarded.
REQ-033 The first edge after rst deasserts SHALL be able to accept a beat.

Verification (NCH=4, W=8, OUT_W=32 unless stated)
REQ-034 The bench SHALL check: in_data=32'h00010204, out_ready=1 -> out_data=0 (XOR=8'h07, odd parity) 2 cycles after acceptance.
REQ-035 The bench SHALL check: in_data=32'h00000003 -> out_data=1; in_data=32'h80000000 with SEXT=0 -> 32'h1, and with SEXT=1 -> 32'hFFFFFFFF.
REQ-036 The bench SHALL check: out_ready=0, three consecutive valid beats -> two accepted, in_ready=0 on the third, out_data stable; then out_ready=1 -> all three beats emerge in order with no loss.
REQ-037 The bench SHALL check: transfer results 1, 0, 1 with SEXT=0 -> checksum=0, count=3; with SEXT=1, transfer 32'hFFFFFFFF then 1 -> checksum=32'hFFFFFFFE, count=2.
REQ-038 The bench SHALL check: sum_clr=1 in the same cycle as a transfer of 32'h1 -> checksum=0 and count=0 next cycle, and the transferred beat is still observed on out_data.
REQ-039 The bench SHALL check: rst pulsed mid-cycle with v1=v2=1 -> out_valid=0 before the next edge, checksum=0, count=0, in_ready=1, and no stale beat appears afterwards.
